aemb_dwb_master: RTL and testbench
==================================

Name: aemb_dwb_master

Overview:
- Synthesizable data-bus initiator for the AEMB data port (dwb_*); drives the same stb/wre/sel/adr/dat/ack protocol the CPU drives.
- Used by host-side loaders and bus traffic generators to issue single byte/half/word reads and writes into AEMB data RAM or peripherals.
- Accepts one command at a time on a valid/ready command port and returns one response per command.
- Performs big-endian byte-lane steering and optional ack-timeout detection.

Parameters:
- AW, 16, byte-address width; bus word address is AW-1:2.
- TMO_CYC, 255, cycles dwb_stb_o may stay high without ack before error (timeout build only); range 1..65535.

Ports:
- sys_clk_i  in  1  clock, all logic on rising edge
- sys_rst_i  in  1  reset; asynchronous, active-high
- cmd_stb_i  in  1  command valid
- cmd_rdy_o  out  1  command ready (high only in IDLE)
- cmd_wre_i  in  1  1=write, 0=read
- cmd_siz_i  in  2  00 byte, 01 half, 10 word, 11 reserved
- cmd_adr_i  in  AW  byte address
- cmd_dat_i  in  32  write data, right-aligned
- rsp_stb_o  out  1  one-cycle response strobe
- rsp_err_o  out  1  error qualifier, valid with rsp_stb_o
- rsp_dat_o  out  32  read data, right-aligned, zero-extended; 0 for writes and errors
- dwb_stb_o  out  1  bus strobe
- dwb_wre_o  out  1  bus write enable
- dwb_sel_o  out  4  byte lane select
- dwb_adr_o  out  AW-2  word address (bits AW-1:2)
- dwb_dat_o  out  32  lane-steered write data
- dwb_dat_i  in  32  read data
- dwb_ack_i  in  1  level acknowledge

Behaviour:
- Reset values: cmd_rdy_o=1 and all other outputs 0. The FSM state is IDLE.
- Reset mid-transaction drops dwb_stb_o immediately (asynchronously). It discards the transaction and emits no response.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - A command is accepted at an edge where cmd_stb_i & cmd_rdy_o. At that edge all bus outputs and a size/offset copy are registered.
  - Legal command: next state BUS, dwb_stb_o=1.
  - Misaligned command (half with adr[0]=1; word with adr[1:0]!=0) or siz=11: next state RESP with err=1. No bus cycle is issued.
- BUS:
  - dwb_stb_o, wre, sel, adr and dat are held stable.
  - The transfer completes at the first edge where dwb_ack_i=1. At that edge dwb_stb_o falls, read data is captured and extracted, and the next state is RESP with err=0.
  - Minimum latency: command accept at edge N, ack sampled at N+1, rsp_stb_o high N+1..N+2, cmd_rdy_o high again after N+2.
- RESP: rsp_stb_o=1 for exactly one cycle, then IDLE. cmd_rdy_o=0 in BUS and RESP.
- dwb_ack_i while not in BUS is ignored.
- Lane steering (big-endian): sel and dat_o come from the lane map below, with data replicated per size. Write data for unused lanes is don't-care and driven with replicated data.
  - Byte: off0→8 [31:24], off1→4 [23:16], off2→2 [15:8], off3→1 [7:0].
  - Half: off0→C [31:16], off2→3 [15:0].
  - Word: F.
- Read extraction uses the same lane map, zero-extended. Reads also drive sel per size/offset.

Optional Feature:
- Macro: AEMB_DWB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering BUS and increments each BUS cycle without ack.
  - If the count reaches TMO_CYC-1 with no ack, dwb_stb_o drops at that edge, the next state is RESP, and rsp_err_o=1 with rsp_dat_o=0.
  - If ack and timeout coincide at the same edge, the ack wins (err=0).
- Undefined: no counter; BUS waits for ack indefinitely.

Decomposition:
- Package aemb_dwb_pkg holds:
  - size encodings (SIZ_BYTE=2'b00, SIZ_HALF=2'b01, SIZ_WORD=2'b10);
  - FSM state encodings;
  - the misalignment predicate as a constant function.
- One sub-module, aemb_dwb_lanes: combinational sel/write-steer/read-extract from siz and adr[1:0], shared by the write and read paths.

Test Plan:
- Write byte 0xA5 to adr 0x0001 with a slave acking 1 cycle after stb → sel=4, adr=0, dat_o[23:16]=A5, single rsp_stb_o, err=0; RAM word 0x11223344 becomes 0x11A53344.
- Read half at adr 0x0006 with RAM word 1 = 0xDEADBEEF → sel=3, adr=1, rsp_dat_o=0x0000BEEF.
- Word write 0xCAFEF00D to 0x0003 → no dwb_stb_o, rsp_err_o=1 one cycle after accept; siz=11 behaves the same.
- Back-to-back: hold cmd_stb_i with 3 word reads while the slave holds ack high continuously → each stb pulse lasts exactly 1 cycle, 3 responses, cmd_rdy_o low in BUS/RESP.
- Timeout build, TMO_CYC=8, ack never asserted → stb high exactly 8 cycles, then rsp_err_o=1. Separately, ack on the 8th cycle → err=0 and data returned.
- Assert sys_rst_i mid-BUS (asynchronously, between edges) → dwb_stb_o low before the next edge, no rsp_stb_o, cmd_rdy_o=1 after release.

Source files
------------

// File: rtl/aemb_dwb_pkg.sv
// Shared encodings and helpers for the AEMB data-bus master.
package aemb_dwb_pkg;

  localparam logic [1:0] SIZ_BYTE = 2'b00;
  localparam logic [1:0] SIZ_HALF = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Reserved size counts as misaligned so it takes the same error path.
  function automatic logic is_misaligned(input logic [1:0] siz, input logic [1:0] off);
    case (siz)
      SIZ_BYTE: return 1'b0;
      SIZ_HALF: return off[0];
      SIZ_WORD: return off != 2'b00;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/aemb_dwb_master_if.sv
// Command, response and dwb_* bus signals of the AEMB data-bus master.
interface aemb_dwb_master_if #(parameter int AW = 16);
  logic          cmd_stb_i;
  logic          cmd_rdy_o;
  logic          cmd_wre_i;
  logic [1:0]    cmd_siz_i;
  logic [AW-1:0] cmd_adr_i;
  logic [31:0]   cmd_dat_i;

  logic          rsp_stb_o;
  logic          rsp_err_o;
  logic [31:0]   rsp_dat_o;

  logic          dwb_stb_o;
  logic          dwb_wre_o;
  logic [3:0]    dwb_sel_o;
  logic [AW-3:0] dwb_adr_o;
  logic [31:0]   dwb_dat_o;
  logic [31:0]   dwb_dat_i;
  logic          dwb_ack_i;

  modport master (
    input  cmd_stb_i, cmd_wre_i, cmd_siz_i, cmd_adr_i, cmd_dat_i, dwb_dat_i, dwb_ack_i,
    output cmd_rdy_o, rsp_stb_o, rsp_err_o, rsp_dat_o,
           dwb_stb_o, dwb_wre_o, dwb_sel_o, dwb_adr_o, dwb_dat_o
  );

  modport slave (
    output cmd_stb_i, cmd_wre_i, cmd_siz_i, cmd_adr_i, cmd_dat_i, dwb_dat_i, dwb_ack_i,
    input  cmd_rdy_o, rsp_stb_o, rsp_err_o, rsp_dat_o,
           dwb_stb_o, dwb_wre_o, dwb_sel_o, dwb_adr_o, dwb_dat_o
  );
endinterface

// File: rtl/aemb_dwb_lanes.sv
// Big-endian byte-lane map: lane select, write replication and read extraction.
module aemb_dwb_lanes
  import aemb_dwb_pkg::*;
(
  input  logic [1:0]  siz,
  input  logic [1:0]  off,
  input  logic [31:0] wdat,
  input  logic [31:0] rdat,
  output logic [3:0]  sel,
  output logic [31:0] wdat_steer,
  output logic [31:0] rdat_ext
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    sel        = 4'h0;
    wdat_steer = wdat;
    rdat_ext   = 32'h0;
    case (siz)
      SIZ_BYTE: begin
        sel        = 4'b1000 >> off;
        wdat_steer = {4{wdat[7:0]}};
        case (off)
          2'd0:    rdat_ext = {24'h0, rdat[31:24]};
          2'd1:    rdat_ext = {24'h0, rdat[23:16]};
          2'd2:    rdat_ext = {24'h0, rdat[15:8]};
          default: rdat_ext = {24'h0, rdat[7:0]};
        endcase
      end
      SIZ_HALF: begin
        sel        = off[1] ? 4'h3 : 4'hC;
        wdat_steer = {2{wdat[15:0]}};
        rdat_ext   = off[1] ? {16'h0, rdat[15:0]} : {16'h0, rdat[31:16]};
      end
      SIZ_WORD: begin
        sel      = 4'hF;
        rdat_ext = rdat;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/aemb_dwb_master.sv
// Single-command AEMB data-bus initiator with big-endian lane steering.
// Define AEMB_DWB_TIMEOUT_EN to abort a bus cycle after TMO_CYC cycles without ack.
module aemb_dwb_master
  import aemb_dwb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int TMO_CYC = 255
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  aemb_dwb_master_if.master    bus
);

  state_t      state;
  logic [1:0]  siz_q;
  logic [1:0]  off_q;
  logic [1:0]  lane_siz;
  logic [1:0]  lane_off;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdat;
  logic [31:0] lane_rdat;

  // In IDLE the lanes see the incoming command; afterwards the registered copy.
  assign lane_siz = (state == ST_IDLE) ? bus.cmd_siz_i      : siz_q;
  assign lane_off = (state == ST_IDLE) ? bus.cmd_adr_i[1:0] : off_q;

  aemb_dwb_lanes u_lanes (
    .siz        (lane_siz),
    .off        (lane_off),
    .wdat       (bus.cmd_dat_i),
    .rdat       (bus.dwb_dat_i),
    .sel        (lane_sel),
    .wdat_steer (lane_wdat),
    .rdat_ext   (lane_rdat)
  );

`ifdef AEMB_DWB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  logic [15:0] tmo_cnt;
`endif

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state         <= ST_IDLE;
      siz_q         <= 2'b00;
      off_q         <= 2'b00;
      bus.cmd_rdy_o <= 1'b1;
      bus.rsp_stb_o <= 1'b0;
      bus.rsp_err_o <= 1'b0;
      bus.rsp_dat_o <= 32'h0;
      bus.dwb_stb_o <= 1'b0;
      bus.dwb_wre_o <= 1'b0;
      bus.dwb_sel_o <= 4'h0;
      bus.dwb_adr_o <= '0;
      bus.dwb_dat_o <= 32'h0;
`ifdef AEMB_DWB_TIMEOUT_EN
      tmo_cnt       <= 16'h0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state)
        ST_IDLE: begin
          if (bus.cmd_stb_i && bus.cmd_rdy_o) begin
            bus.cmd_rdy_o <= 1'b0;
            siz_q         <= bus.cmd_siz_i;
            off_q         <= bus.cmd_adr_i[1:0];
            bus.dwb_wre_o <= bus.cmd_wre_i;
            bus.dwb_sel_o <= lane_sel;
            bus.dwb_adr_o <= bus.cmd_adr_i[AW-1:2];
            bus.dwb_dat_o <= lane_wdat;
            if (is_misaligned(bus.cmd_siz_i, bus.cmd_adr_i[1:0])) begin
              state         <= ST_RESP;
              bus.rsp_stb_o <= 1'b1;
              bus.rsp_err_o <= 1'b1;
              bus.rsp_dat_o <= 32'h0;
            end else begin
              state         <= ST_BUS;
              bus.dwb_stb_o <= 1'b1;
`ifdef AEMB_DWB_TIMEOUT_EN
              tmo_cnt       <= 16'h0;
`endif
            end
          end
        end

        ST_BUS: begin
          if (bus.dwb_ack_i) begin
            state         <= ST_RESP;
            bus.dwb_stb_o <= 1'b0;
            bus.rsp_stb_o <= 1'b1;
            bus.rsp_err_o <= 1'b0;
            bus.rsp_dat_o <= bus.dwb_wre_o ? 32'h0 : lane_rdat;
          end
`ifdef AEMB_DWB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state         <= ST_RESP;
            bus.dwb_stb_o <= 1'b0;
            bus.rsp_stb_o <= 1'b1;
            bus.rsp_err_o <= 1'b1;
            bus.rsp_dat_o <= 32'h0;
          end else begin
            tmo_cnt       <= tmo_cnt + 16'h1;
          end
`endif
        end

        ST_RESP: begin
          state         <= ST_IDLE;
          bus.rsp_stb_o <= 1'b0;
          bus.rsp_err_o <= 1'b0;
          bus.rsp_dat_o <= 32'h0;
          bus.cmd_rdy_o <= 1'b1;
        end

        default: begin
          state         <= ST_IDLE;
          bus.cmd_rdy_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aemb_dwb_master.sv
// Scoreboard bench for aemb_dwb_master: byte-addressed memory model, bus slave, response monitor.
module tb_aemb_dwb_master;
  import aemb_dwb_pkg::*;

  localparam int AW = 16;
`ifdef AEMB_DWB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aemb_dwb_master_if #(.AW(AW)) bus ();

  aemb_dwb_master #(.AW(AW), .TMO_CYC(TMO)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: 64 bytes of memory, byte k of word w at address 4w+k (big-endian).
  logic [7:0]  model_b [64];
  logic [31:0] slave_mem [16];

  typedef struct packed { logic err; logic [31:0] dat; } rsp_t;
  typedef struct packed { logic wre; logic [3:0] sel; logic [13:0] adr; logic [31:0] dat; } xfer_t;
  rsp_t  rsp_q [$];
  xfer_t bus_q [$];
  logic [31:0] last_rsp_dat;

  function automatic int nbytes(input logic [1:0] siz);
    case (siz)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    for (int k = 0; k < 4; k++) model_b[4*w+k] = v[31-8*k -: 8];
    slave_mem[w] = v;
  endtask

  task automatic expect_cmd(input logic wre, input logic [1:0] siz, input logic [15:0] adr,
                            input logic [31:0] dat, input bit tmo);
    int n = nbytes(siz);
    int a = int'(adr);
    rsp_t r;
    xfer_t x;
    logic [3:0] top_lane = 4'b1000;
    if (n == 0 || (a % n) != 0) begin
      r = '{err: 1'b1, dat: 32'h0};
      rsp_q.push_back(r);
      return;
    end
    x.wre = wre;
    x.adr = adr[15:2];
    x.sel = 4'h0;
    for (int i = 0; i < n; i++) x.sel |= top_lane >> ((a + i) % 4);
    x.dat = (n == 1) ? {4{dat[7:0]}} : (n == 2) ? {2{dat[15:0]}} : dat;
    bus_q.push_back(x);
    r = '{err: 1'b0, dat: 32'h0};
    if (tmo) r.err = 1'b1;
    else if (wre) begin
      for (int i = 0; i < n; i++) model_b[a+i] = dat[8*(n-1-i) +: 8];
    end else begin
      for (int i = 0; i < n; i++) r.dat = {r.dat[23:0], model_b[a+i]};
    end
    rsp_q.push_back(r);
  endtask

  // Driver: call at a negedge; returns at the negedge after acceptance with cmd_stb_i still high.
  task automatic issue(input logic wre, input logic [1:0] siz, input logic [15:0] adr,
                       input logic [31:0] dat, input bit tmo, output int acc);
    int w = 0;
    bus.cmd_wre_i = wre;
    bus.cmd_siz_i = siz;
    bus.cmd_adr_i = adr;
    bus.cmd_dat_i = dat;
    bus.cmd_stb_i = 1'b1;
    acc = -1;
    while (!bus.cmd_rdy_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_rdy_o) begin
      fail_now("accept_timeout");
      bus.cmd_stb_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    expect_cmd(wre, siz, adr, dat, tmo);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((rsp_q.size() != 0 || !bus.cmd_rdy_o) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (rsp_q.size() != 0 || !bus.cmd_rdy_o) fail_now("drain_timeout");
  endtask

  // Response monitor.
  always @(negedge clk) begin
    rsp_t r;
    if (!rst) begin
      if (bus.rsp_stb_o) begin
        if (rsp_q.size() == 0) fail_now("rsp_unexpected");
        else begin
          r = rsp_q.pop_front();
          check("rsp_err", bus.rsp_err_o, r.err);
          check("rsp_dat", bus.rsp_dat_o, r.dat);
          last_rsp_dat = bus.rsp_dat_o;
        end
      end
      if (bus.dwb_stb_o || bus.rsp_stb_o) check("rdy_busy", bus.cmd_rdy_o, 1'b0);
    end
  end

  // Bus slave: 0 random delay, 1 ack held high, 2 never ack, 3 fixed delay.
  int ack_mode    = 3;
  int fixed_delay = 1;
  int cur_delay   = 0;
  int cnt         = 0;
  int width       = 0;
  int last_width  = 0;
  bit in_xfer     = 1'b0;

  always @(negedge clk) begin
    xfer_t x;
    logic ack;
    int wi;
    if (rst) begin
      bus.dwb_ack_i = 1'b0;
      bus.dwb_dat_i = 32'h0;
      in_xfer = 1'b0;
      cnt = 0;
    end else begin
      if (in_xfer && bus.dwb_ack_i) check("stb_drop", bus.dwb_stb_o, 1'b0);
      if (bus.dwb_stb_o) begin
        if (!in_xfer) begin
          in_xfer = 1'b1;
          width = 0;
          cnt = 0;
          cur_delay = (ack_mode == 0) ? int'($urandom_range(0, 3)) : fixed_delay;
          if (bus_q.size() == 0) fail_now("bus_unexpected");
          else begin
            x = bus_q.pop_front();
            check("bus_wre", bus.dwb_wre_o, x.wre);
            check("bus_sel", bus.dwb_sel_o, x.sel);
            check("bus_adr", bus.dwb_adr_o, x.adr);
            if (x.wre) check("bus_dat", bus.dwb_dat_o, x.dat);
          end
        end
        width++;
        case (ack_mode)
          1:       ack = 1'b1;
          2:       ack = 1'b0;
          default: ack = (cnt >= cur_delay);
        endcase
        cnt++;
        wi = int'(bus.dwb_adr_o[3:0]);
        bus.dwb_dat_i = slave_mem[wi];
        if (ack && bus.dwb_wre_o)
          for (int k = 0; k < 4; k++)
            if (bus.dwb_sel_o[k]) slave_mem[wi][8*k +: 8] = bus.dwb_dat_o[8*k +: 8];
        bus.dwb_ack_i = ack;
      end else begin
        if (in_xfer) last_width = width;
        in_xfer = 1'b0;
        bus.dwb_ack_i = (ack_mode == 1);
        bus.dwb_dat_i = $urandom;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1, acc2;
    int n;
    logic [1:0]  siz;
    logic [15:0] adr;

    for (int i = 0; i < 64; i++) model_b[i] = 8'($urandom);
    for (int w = 0; w < 16; w++)
      slave_mem[w] = {model_b[4*w], model_b[4*w+1], model_b[4*w+2], model_b[4*w+3]};
    set_word(0, 32'h11223344);
    set_word(1, 32'hDEADBEEF);

    bus.cmd_stb_i = 1'b0;
    bus.cmd_wre_i = 1'b0;
    bus.cmd_siz_i = 2'b00;
    bus.cmd_adr_i = '0;
    bus.cmd_dat_i = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_rdy",     bus.cmd_rdy_o, 1'b1);
    check("rst_rsp_stb", bus.rsp_stb_o, 1'b0);
    check("rst_rsp_err", bus.rsp_err_o, 1'b0);
    check("rst_rsp_dat", bus.rsp_dat_o, 32'h0);
    check("rst_dwb_stb", bus.dwb_stb_o, 1'b0);
    check("rst_dwb_wre", bus.dwb_wre_o, 1'b0);
    check("rst_dwb_sel", bus.dwb_sel_o, 4'h0);
    check("rst_dwb_adr", bus.dwb_adr_o, 14'h0);
    check("rst_dwb_dat", bus.dwb_dat_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Byte write into lane [23:16], slave acks one cycle after stb.
    ack_mode = 3; fixed_delay = 1;
    issue(1'b1, SIZ_BYTE, 16'h0001, 32'h000000A5, 1'b0, acc0);
    bus.cmd_stb_i = 1'b0;
    wait_idle();
    check("ram_word0", slave_mem[0], 32'h11A53344);

    // Half read from the low half of word 1.
    issue(1'b0, SIZ_HALF, 16'h0006, 32'h0, 1'b0, acc0);
    bus.cmd_stb_i = 1'b0;
    wait_idle();
    check("half_read", last_rsp_dat, 32'h0000BEEF);

    // Misaligned word and reserved size: immediate error, no bus cycle.
    issue(1'b1, SIZ_WORD, 16'h0003, 32'hCAFEF00D, 1'b0, acc0);
    check("err_latency_mis", bus.rsp_stb_o, 1'b1);
    bus.cmd_stb_i = 1'b0;
    wait_idle();
    issue(1'b0, SIZ_RSVD, 16'h0000, 32'h0, 1'b0, acc0);
    check("err_latency_rsv", bus.rsp_stb_o, 1'b1);
    bus.cmd_stb_i = 1'b0;
    wait_idle();

    // Back-to-back word reads with ack held high: one accept every 3 cycles.
    ack_mode = 1;
    repeat (2) @(negedge clk);
    issue(1'b0, SIZ_WORD, 16'h0008, 32'h0, 1'b0, acc0);
    issue(1'b0, SIZ_WORD, 16'h000C, 32'h0, 1'b0, acc1);
    issue(1'b0, SIZ_WORD, 16'h0010, 32'h0, 1'b0, acc2);
    bus.cmd_stb_i = 1'b0;
    wait_idle();
    check("b2b_gap1", 32'(acc1 - acc0), 32'd3);
    check("b2b_gap2", 32'(acc2 - acc1), 32'd3);
    check("b2b_width", 32'(last_width), 32'd1);
    ack_mode = 0;
    @(negedge clk);

    // Randomised traffic.
    for (int t = 0; t < 80; t++) begin
      siz = ($urandom_range(0, 7) == 0) ? SIZ_RSVD : 2'($urandom_range(0, 2));
      adr = 16'($urandom_range(0, 63));
      n = nbytes(siz);
      if (n != 0 && $urandom_range(0, 3) != 0) adr = adr & ~16'(n - 1);
      issue(1'($urandom), siz, adr, $urandom, 1'b0, acc0);
      if ($urandom_range(0, 2) == 0) begin
        bus.cmd_stb_i = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    bus.cmd_stb_i = 1'b0;
    wait_idle();

`ifdef AEMB_DWB_TIMEOUT_EN
    ack_mode = 2;
    issue(1'b0, SIZ_WORD, 16'h0020, 32'h0, 1'b1, acc0);
    bus.cmd_stb_i = 1'b0;
    wait_idle();
    check("tmo_width", 32'(last_width), 32'd8);
    ack_mode = 3; fixed_delay = 7;
    issue(1'b0, SIZ_WORD, 16'h0024, 32'h0, 1'b0, acc0);
    bus.cmd_stb_i = 1'b0;
    wait_idle();
    check("tmo_ack_width", 32'(last_width), 32'd8);
    check("tmo_ack_data", last_rsp_dat, slave_mem[9]);
`endif

    // Asynchronous reset in the middle of a bus cycle.
    ack_mode = 2;
    issue(1'b0, SIZ_WORD, 16'h0014, 32'h0, 1'b0, acc0);
    bus.cmd_stb_i = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_stb", bus.dwb_stb_o, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_stb", bus.dwb_stb_o, 1'b0);
    rsp_q.delete();
    bus_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_rdy", bus.cmd_rdy_o, 1'b1);
    check("rst_rel_rsp", bus.rsp_stb_o, 1'b0);

    ack_mode = 0;
    issue(1'b0, SIZ_BYTE, 16'h0003, 32'h0, 1'b0, acc0);
    bus.cmd_stb_i = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
